// File: rtl/scene_update_scheduler.sv
// scene_update_scheduler
//   Queues sphere descriptors from the SPI receiver and commits them to the
//   shared sphere register only at a safe point. A safe point is a line
//   boundary (or a frame boundary) with every worker idle, so no rendered line
//   ever mixes two scene states. The block commits at most one packet per
//   boundary, and packets commit strictly in arrival order.
//
// Ports
//   CLK100MHZ      system clock, rising edge
//   ck_rst         asynchronous active-high reset (deassertion synchronised here)
//   recv_dv        one-cycle strobe, recv_64bit valid
//   recv_64bit     packed sphere descriptor
//   line_start     level, VGA requesting next line
//   frame_start    level, vertical blank start
//   workers_busy   OR of all worker busy flags
//   sphere_out     committed sphere, feeds all workers
//   sphere_commit  one-cycle pulse, sphere_out just changed
//   recv_interrupt registered, high = MCU may send
//   pending        FIFO occupancy
//   overflow       sticky, a packet was dropped
module scene_update_scheduler #(
  parameter int          DEPTH           = 4,
  parameter bit          COMMIT_ON_FRAME = 1'b0,
  parameter logic [63:0] RESET_SPHERE    = 64'd0
) (
  input  logic                   CLK100MHZ,
  input  logic                   ck_rst,
  input  logic                   recv_dv,
  input  logic [63:0]            recv_64bit,
  input  logic                   line_start,
  input  logic                   frame_start,
  input  logic                   workers_busy,
  output logic [63:0]            sphere_out,
  output logic                   sphere_commit,
  output logic                   recv_interrupt,
  output logic [$clog2(DEPTH):0] pending,
  output logic                   overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
  localparam logic [PW-1:0] HALF_P  = PW'(DEPTH / 2);

  typedef enum logic [1:0] {IDLE, WAIT_SAFE, COMMIT, HOLD} state_t;

  // Reset asserts immediately, releases two edges after ck_rst drops.
  logic [1:0] rst_sync_q, rst_sync_d;
  logic       rst;

  assign rst_sync_d = {rst_sync_q[0], 1'b0};

  always_ff @(posedge CLK100MHZ or posedge ck_rst) begin
    if (ck_rst) rst_sync_q <= 2'b11;
    else        rst_sync_q <= rst_sync_d;
  end

  assign rst = rst_sync_q[1];

  state_t          state_q, state_d;
  logic [63:0]     mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   pending_q, pending_d;
  logic [63:0]     sphere_out_q, sphere_out_d;
  logic            sphere_commit_q, sphere_commit_d;
  logic            recv_interrupt_q, recv_interrupt_d;
  logic            overflow_q, overflow_d;

  logic strobe, safe, full, push, pop;

  assign strobe = COMMIT_ON_FRAME ? frame_start : line_start;
  assign safe   = ~workers_busy & strobe;
  assign full   = (pending_q == DEPTH_P);
  // A pop on the same edge frees the slot, so a full FIFO still accepts.
  assign push   = recv_dv & (~full | pop);

  // FSM: state register
  always_ff @(posedge CLK100MHZ or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (pending_q != '0) state_d = WAIT_SAFE;
      WAIT_SAFE: if (safe)            state_d = COMMIT;
      COMMIT:                         state_d = HOLD;
      // Wait for the boundary strobe to drop: one commit per boundary.
      HOLD:      if (!strobe)         state_d = IDLE;
      default:                        state_d = IDLE;
    endcase
  end

  // FSM: outputs. The commit decision was taken on entering COMMIT, so a
  // late workers_busy does not cancel it.
  always_comb begin
    pop = (state_q == COMMIT);
  end

  // Datapath next-state
  always_comb begin
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    pending_d       = pending_q;
    sphere_out_d    = sphere_out_q;
    sphere_commit_d = pop;
    overflow_d      = overflow_q | (recv_dv & ~push);
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop) begin
      rd_ptr_d     = rd_ptr_q + AW'(1);
      sphere_out_d = mem_q[rd_ptr_q];
    end
    case ({push, pop})
      2'b10:   pending_d = pending_q + PW'(1);
      2'b01:   pending_d = pending_q - PW'(1);
      default: pending_d = pending_q;
    endcase
    recv_interrupt_d = (pending_d <= HALF_P) & ~overflow_d;
  end

  always_ff @(posedge CLK100MHZ or posedge rst) begin
    if (rst) begin
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      pending_q        <= '0;
      sphere_out_q     <= RESET_SPHERE;
      sphere_commit_q  <= 1'b0;
      recv_interrupt_q <= 1'b1;
      overflow_q       <= 1'b0;
    end else begin
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      pending_q        <= pending_d;
      sphere_out_q     <= sphere_out_d;
      sphere_commit_q  <= sphere_commit_d;
      recv_interrupt_q <= recv_interrupt_d;
      overflow_q       <= overflow_d;
    end
  end

  // Storage needs no reset; pointers and occupancy define validity.
  always_ff @(posedge CLK100MHZ) begin
    if (push) mem_q[wr_ptr_q] <= recv_64bit;
  end

  assign sphere_out     = sphere_out_q;
  assign sphere_commit  = sphere_commit_q;
  assign recv_interrupt = recv_interrupt_q;
  assign pending        = pending_q;
  assign overflow       = overflow_q;

endmodule

// File: tb/tb_scene_update_scheduler.sv
// Testbench for scene_update_scheduler: directed scenarios against constant
// expectations plus a randomized run against a queue-based reference model.
module tb_scene_update_scheduler;

  localparam int          DEPTH = 4;
  localparam logic [63:0] RST_S = 64'hDEAD_BEEF_0000_0001;

  logic        clk = 1'b0;
  logic        ck_rst = 1'b1;
  logic        recv_dv = 1'b0;
  logic [63:0] recv_64bit = '0;
  logic        line_start = 1'b0;
  logic        frame_start = 1'b0;
  logic        workers_busy = 1'b0;

  logic [63:0] out0, out1;
  logic        cm0, cm1, int0, int1, ovf0, ovf1;
  logic [2:0]  pend0, pend1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  scene_update_scheduler #(.DEPTH(DEPTH), .COMMIT_ON_FRAME(1'b0), .RESET_SPHERE(RST_S)) u_line (
    .CLK100MHZ(clk), .ck_rst(ck_rst), .recv_dv(recv_dv), .recv_64bit(recv_64bit),
    .line_start(line_start), .frame_start(frame_start), .workers_busy(workers_busy),
    .sphere_out(out0), .sphere_commit(cm0), .recv_interrupt(int0),
    .pending(pend0), .overflow(ovf0));

  scene_update_scheduler #(.DEPTH(DEPTH), .COMMIT_ON_FRAME(1'b1), .RESET_SPHERE(RST_S)) u_frame (
    .CLK100MHZ(clk), .ck_rst(ck_rst), .recv_dv(recv_dv), .recv_64bit(recv_64bit),
    .line_start(line_start), .frame_start(frame_start), .workers_busy(workers_busy),
    .sphere_out(out1), .sphere_commit(cm1), .recv_interrupt(int1),
    .pending(pend1), .overflow(ovf1));

  // Reference model of the line-mode instance. Phase: 0 nothing to do,
  // 1 waiting for a boundary, 2 commit decided, 3 waiting for boundary end.
  logic [63:0] mq[$];
  logic [63:0] m_out;
  bit          m_commit, m_ovf, m_int;
  int          m_ph;
  int          m_rst = 0;

  function automatic void mdl_reset();
    mq.delete();
    m_out = RST_S; m_commit = 0; m_ovf = 0; m_int = 1; m_ph = 0;
  endfunction

  function automatic void mdl_step();
    int  npre;
    bit  pop, strobe, safe;
    npre   = mq.size();
    strobe = line_start;
    safe   = strobe && !workers_busy;
    pop    = (m_ph == 2);
    m_commit = 0;
    if (pop) begin
      m_out = mq.pop_front();
      m_commit = 1;
    end
    if (recv_dv) begin
      if (npre < DEPTH || pop) mq.push_back(recv_64bit);
      else m_ovf = 1;
    end
    case (m_ph)
      0: m_ph = (npre > 0) ? 1 : 0;
      1: m_ph = safe ? 2 : 1;
      2: m_ph = 3;
      default: m_ph = strobe ? 3 : 0;
    endcase
    m_int = (mq.size() <= DEPTH / 2) && !m_ovf;
  endfunction

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    if (ck_rst) begin m_rst = 2; mdl_reset(); end
    else if (m_rst > 0) begin m_rst--; mdl_reset(); end
    else mdl_step();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [63:0] d);
    recv_dv = 1'b1; recv_64bit = d;
    tick();
    recv_dv = 1'b0;
  endtask

  task automatic do_reset();
    ck_rst = 1'b1; recv_dv = 1'b0; line_start = 1'b0; frame_start = 1'b0; workers_busy = 1'b0;
    tick(); tick();
    ck_rst = 1'b0;
    tick(); tick(); tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (out0 !== RST_S) begin errors++; $display("FAIL rst_init_out: got %h want %h", out0, RST_S); end
    checks++; if (pend0 !== 3'd0 || ovf0 !== 1'b0 || int0 !== 1'b1 || cm0 !== 1'b0) begin
      errors++; $display("FAIL rst_init_flags: pend=%0d ovf=%b int=%b cm=%b want 0 0 1 0", pend0, ovf0, int0, cm0); end
    push(64'h1111); push(64'h2222);
    checks++; if (pend0 !== 3'd2) begin errors++; $display("FAIL rst_queued: pending %0d want 2", pend0); end
    @(negedge clk);
    ck_rst = 1'b1; #1;
    checks++; if (pend0 !== 3'd0 || out0 !== RST_S || ovf0 !== 1'b0 || int0 !== 1'b1 || cm0 !== 1'b0) begin
      errors++; $display("FAIL rst_async: pend=%0d out=%h ovf=%b int=%b cm=%b", pend0, out0, ovf0, int0, cm0); end
    @(posedge clk); #1;
    ck_rst = 1'b0; m_rst = 2; mdl_reset();
    line_start = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++; if (cm0 !== 1'b0 || pend0 !== 3'd0 || out0 !== RST_S) begin
        errors++; $display("FAIL rst_after_%0d: cm=%b pend=%0d out=%h want 0 0 %h", i, cm0, pend0, out0, RST_S); end
    end
    line_start = 1'b0; tick();
  endtask

  task automatic test_single();
    logic [63:0] pkt;
    pkt = 64'hA5A5_0000_1234_5678;
    do_reset();
    line_start = 1'b1; workers_busy = 1'b0;
    push(pkt);
    for (int e = 1; e <= 4; e++) begin
      bit want_cm;
      want_cm = (e == 3);
      tick();
      checks++; if (cm0 !== want_cm) begin errors++; $display("FAIL single_commit_e%0d: got %b want %b", e, cm0, want_cm); end
      checks++; if (out0 !== ((e >= 3) ? pkt : RST_S)) begin
        errors++; $display("FAIL single_out_e%0d: got %h want %h", e, out0, (e >= 3) ? pkt : RST_S); end
    end
    checks++; if (pend0 !== 3'd0) begin errors++; $display("FAIL single_pending: got %0d want 0", pend0); end
    line_start = 1'b0; tick(); tick();
  endtask

  task automatic test_busy_gating();
    int n;
    logic [63:0] pkt;
    pkt = 64'h0BAD_CAFE_5555_AAAA;
    do_reset();
    workers_busy = 1'b1; line_start = 1'b1;
    push(pkt);
    n = 0;
    for (int i = 0; i < 50; i++) begin tick(); if (cm0) n++; end
    checks++; if (n != 0 || out0 !== RST_S) begin errors++; $display("FAIL busy_hold: commits=%0d out=%h want 0 %h", n, out0, RST_S); end
    workers_busy = 1'b0;
    tick();
    checks++; if (cm0 !== 1'b0) begin errors++; $display("FAIL busy_edge1: commit %b want 0", cm0); end
    tick();
    checks++; if (cm0 !== 1'b1 || out0 !== pkt) begin errors++; $display("FAIL busy_edge2: cm=%b out=%h want 1 %h", cm0, out0, pkt); end
    line_start = 1'b0; tick(); tick();
  endtask

  task automatic test_one_per_boundary();
    logic [63:0] p [3];
    int n;
    for (int i = 0; i < 3; i++) p[i] = {$urandom, $urandom};
    do_reset();
    for (int i = 0; i < 3; i++) push(p[i]);
    line_start = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin tick(); if (cm0) n++; end
    checks++; if (n != 1 || pend0 !== 3'd2 || out0 !== p[0]) begin
      errors++; $display("FAIL boundary_first: commits=%0d pend=%0d out=%h want 1 2 %h", n, pend0, out0, p[0]); end
    for (int k = 1; k < 3; k++) begin
      line_start = 1'b0; tick();
      line_start = 1'b1;
      n = 0;
      for (int i = 0; i < 5; i++) begin tick(); if (cm0) n++; end
      checks++; if (n != 1 || out0 !== p[k]) begin
        errors++; $display("FAIL boundary_%0d: commits=%0d out=%h want 1 %h", k, n, out0, p[k]); end
    end
    checks++; if (pend0 !== 3'd0) begin errors++; $display("FAIL boundary_drain: pending %0d want 0", pend0); end
    line_start = 1'b0; tick();
  endtask

  task automatic test_overflow();
    logic [63:0] first;
    first = 64'hF0F0_0000_0000_0001;
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      int  wp;
      bit  wi, wo;
      wp = (i > 4) ? 4 : i;
      wo = (i == 5);
      wi = (i < 3);
      push((i == 1) ? first : 64'(i));
      checks++; if (pend0 !== 3'(wp) || int0 !== wi || ovf0 !== wo) begin
        errors++; $display("FAIL ovf_push%0d: pend=%0d int=%b ovf=%b want %0d %b %b", i, pend0, int0, ovf0, wp, wi, wo); end
    end
    line_start = 1'b1;
    tick();
    push(64'h7777);
    checks++; if (pend0 !== 3'd4 || cm0 !== 1'b1 || out0 !== first || ovf0 !== 1'b1) begin
      errors++; $display("FAIL ovf_pushpop: pend=%0d cm=%b out=%h ovf=%b want 4 1 %h 1", pend0, cm0, out0, ovf0, first); end
    line_start = 1'b0; tick();
  endtask

  task automatic test_frame_mode();
    int n;
    logic [63:0] pkt;
    pkt = 64'h1234_5678_9ABC_DEF0;
    do_reset();
    push(pkt);
    n = 0;
    for (int i = 0; i < 20; i++) begin line_start = ~line_start; tick(); if (cm1) n++; end
    line_start = 1'b0;
    checks++; if (n != 0 || pend1 !== 3'd1) begin errors++; $display("FAIL frame_no_line: commits=%0d pend=%0d want 0 1", n, pend1); end
    frame_start = 1'b1; tick();
    frame_start = 1'b0;
    n = 0;
    for (int i = 0; i < 6; i++) begin tick(); if (cm1) n++; end
    checks++; if (n != 1 || out1 !== pkt || pend1 !== 3'd0) begin
      errors++; $display("FAIL frame_commit: commits=%0d out=%h pend=%0d want 1 %h 0", n, out1, pend1, pkt); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) do_reset();
      recv_dv      = ($urandom_range(0, 3) == 0);
      recv_64bit   = {$urandom, $urandom};
      line_start   = ($urandom_range(0, 2) != 0) ? line_start : ~line_start;
      frame_start  = $urandom_range(0, 1);
      workers_busy = ($urandom_range(0, 2) == 0);
      tick();
      checks++; if (out0 !== m_out) begin errors++; $display("FAIL rnd_out c%0d: got %h want %h", c, out0, m_out); end
      checks++; if (cm0 !== m_commit) begin errors++; $display("FAIL rnd_commit c%0d: got %b want %b", c, cm0, m_commit); end
      checks++; if (pend0 !== 3'(mq.size())) begin errors++; $display("FAIL rnd_pending c%0d: got %0d want %0d", c, pend0, mq.size()); end
      checks++; if (ovf0 !== m_ovf) begin errors++; $display("FAIL rnd_overflow c%0d: got %b want %b", c, ovf0, m_ovf); end
      checks++; if (int0 !== m_int) begin errors++; $display("FAIL rnd_interrupt c%0d: got %b want %b", c, int0, m_int); end
    end
    recv_dv = 1'b0;
  endtask

  initial begin
    mdl_reset();
    test_reset();
    test_single();
    test_busy_gating();
    test_one_per_boundary();
    test_overflow();
    test_frame_mode();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
